// File: rtl/uart_pkg.sv
// Shared definitions for the UART interrupt controller.
//   uart_iir_id_e : IIR[3:0] interrupt identification codes
//   IER_*         : bit indices into the IER register
//   trig_level()  : maps the 2-bit RX trigger encoding to a character count
package uart_pkg;

    typedef enum logic [3:0] {
        IIR_MS   = 4'b0000,  // modem status change
        IIR_NONE = 4'b0001,  // nothing pending
        IIR_THRE = 4'b0010,  // transmit holding register empty
        IIR_RDA  = 4'b0100,  // RX data available
        IIR_LS   = 4'b0110,  // receiver line status
        IIR_CTO  = 4'b1100   // character timeout
    } uart_iir_id_e;

    localparam int unsigned IER_ERBFI = 0;
    localparam int unsigned IER_ETBEI = 1;
    localparam int unsigned IER_ELSI  = 2;
    localparam int unsigned IER_EDSSI = 3;

    function automatic logic [3:0] trig_level(input logic [1:0] enc);
        case (enc)
            2'b00:   trig_level = 4'd1;
            2'b01:   trig_level = 4'd4;
            2'b10:   trig_level = 4'd8;
            default: trig_level = 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/uart_char_timeout.sv
// Character-timeout counter. Counts character-time ticks while enabled and
// saturates at TimeoutChars; the saturated count is the pending condition.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : counting allowed (FIFO mode, ERBFI, FIFO non-empty)
//   clr_i         : restart (push, pop or empty FIFO); wins over a tick
//   tick_i        : one pulse per character time
//   pend_d_o      : next-state timeout pending, for the registered IIR
module uart_char_timeout
    import uart_pkg::*;
#(
    parameter int unsigned TimeoutChars = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic tick_i,
    output logic pend_d_o
);

    localparam int unsigned W = $clog2(TimeoutChars + 1);
    localparam logic [W-1:0] Limit = W'(TimeoutChars);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && tick_i && cnt_q != Limit)
            cnt_d = cnt_q + W'(1);
    end

    // Pending is exposed from the next state so the top-level IIR register
    // reflects it one cycle after the causing tick.
    assign pend_d_o = (cnt_d == Limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_intr_ctrl.sv
// 16550-style UART interrupt controller: prioritises the interrupt sources
// and presents a registered IIR identification and interrupt request.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   ier_i              : IER {EDSSI, ELSI, ETBEI, ERBFI}
//   fifo_en_i          : FIFO mode enable
//   rx_trig_lvl_i      : RX trigger encoding (1/4/8/14)
//   rx_fifo_cnt_i      : RX FIFO fill level
//   rx_push_i/rx_pop_i : RX FIFO write / RBR read
//   lsr_err_i          : OR of sticky LSR error bits
//   msr_delta_i        : OR of MSR delta bits
//   tx_empty_i         : THR/TX FIFO empty
//   thr_write_i        : THR write strobe
//   iir_read_i         : IIR read strobe
//   char_tick_i        : one pulse per character time
//   irq_o, iir_id_o    : interrupt request and IIR[3:0]
// Build option: UART_CHAR_TIMEOUT_EN includes the character-timeout source.
module uart_intr_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned RxFifoDepth  = 16,
    parameter  int unsigned TimeoutChars = 4,
    localparam int unsigned CntW         = $clog2(RxFifoDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [3:0]      ier_i,
    input  logic            fifo_en_i,
    input  logic [1:0]      rx_trig_lvl_i,
    input  logic [CntW-1:0] rx_fifo_cnt_i,
    input  logic            rx_push_i,
    input  logic            rx_pop_i,
    input  logic            lsr_err_i,
    input  logic            msr_delta_i,
    input  logic            tx_empty_i,
    input  logic            thr_write_i,
    input  logic            iir_read_i,
    input  logic            char_tick_i,
    output logic            irq_o,
    output logic [3:0]      iir_id_o
);

    uart_iir_id_e iir_q, iir_d;
    logic         tx_empty_q, etbei_q;
    logic         thre_pend, thre_pend_d, thre_set, thre_clr;
    logic [CntW-1:0] rx_lvl;
    logic         rda, to_pend_d;

    assign iir_id_o = iir_q;

    // Non-FIFO mode behaves as a one-character holding register.
    assign rx_lvl = fifo_en_i ? CntW'(trig_level(rx_trig_lvl_i)) : CntW'(1);
    assign rda    = ier_i[IER_ERBFI] && (rx_fifo_cnt_i >= rx_lvl);

    // THRE is edge-triggered: either TX becoming empty with ETBEI on, or
    // ETBEI being switched on while TX is already empty.
    assign thre_set = ier_i[IER_ETBEI] && tx_empty_i && (!tx_empty_q || !etbei_q);
    assign thre_clr = thr_write_i || (iir_read_i && iir_q == IIR_THRE);
    assign thre_pend_d = thre_set || (thre_pend && !thre_clr);

`ifdef UART_CHAR_TIMEOUT_EN
    uart_char_timeout #(
        .TimeoutChars(TimeoutChars)
    ) u_char_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (fifo_en_i && ier_i[IER_ERBFI] && rx_fifo_cnt_i != '0),
        .clr_i   (rx_push_i || rx_pop_i || rx_fifo_cnt_i == '0),
        .tick_i  (char_tick_i),
        .pend_d_o(to_pend_d)
    );
`else
    logic unused_timeout_inputs;
    assign unused_timeout_inputs = ^{char_tick_i, rx_push_i, rx_pop_i};
    assign to_pend_d = 1'b0;
`endif

    // Priority encode from next-state pending bits so the registered IIR
    // moves one cycle after the causing input.
    always_comb begin
        iir_d = IIR_NONE;
        if (lsr_err_i && ier_i[IER_ELSI])         iir_d = IIR_LS;
        else if (rda)                             iir_d = IIR_RDA;
        else if (to_pend_d)                       iir_d = IIR_CTO;
        else if (thre_pend_d && ier_i[IER_ETBEI]) iir_d = IIR_THRE;
        else if (msr_delta_i && ier_i[IER_EDSSI]) iir_d = IIR_MS;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_empty_q <= 1'b1;
            etbei_q    <= 1'b0;
            thre_pend  <= 1'b0;
            iir_q      <= IIR_NONE;
            irq_o      <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty_i;
            etbei_q    <= ier_i[IER_ETBEI];
            thre_pend  <= thre_pend_d;
            iir_q      <= iir_d;
            irq_o      <= (iir_d != IIR_NONE);
        end
    end

endmodule

// File: tb/tb_uart_intr_ctrl.sv
// Scoreboard bench for uart_intr_ctrl: stimulus at negedges pushes the
// expected IIR for the following posedge; a monitor pops and compares.
module tb_uart_intr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ier;
    logic       fifo_en;
    logic [1:0] trig;
    logic [4:0] rx_cnt;
    logic       rx_push, rx_pop, lsr_err, msr_delta;
    logic       tx_empty, thr_write, iir_read, char_tick;
    logic       irq;
    logic [3:0] iir;

`ifdef UART_CHAR_TIMEOUT_EN
    localparam logic [3:0] CtoExp = 4'b1100;
`else
    localparam logic [3:0] CtoExp = 4'b0001;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] iir;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done = 0;

    always #5 clk = ~clk;

    uart_intr_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ier_i        (ier),
        .fifo_en_i    (fifo_en),
        .rx_trig_lvl_i(trig),
        .rx_fifo_cnt_i(rx_cnt),
        .rx_push_i    (rx_push),
        .rx_pop_i     (rx_pop),
        .lsr_err_i    (lsr_err),
        .msr_delta_i  (msr_delta),
        .tx_empty_i   (tx_empty),
        .thr_write_i  (thr_write),
        .iir_read_i   (iir_read),
        .char_tick_i  (char_tick),
        .irq_o        (irq),
        .iir_id_o     (iir)
    );

    // Expected value applies to the state after the next rising edge.
    task automatic expect_iir(input logic [3:0] e, input string name);
        exp_t x;
        x.cyc  = cyc + 1;
        x.iir  = e;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic nxt();
        @(negedge clk);
        rx_push = 0; rx_pop = 0; char_tick = 0; iir_read = 0; thr_write = 0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic exp_irq;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                exp_irq = (e.iir != 4'b0001);
                n_cmp += 2;
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL %s: stale expectation cycle %0d at cycle %0d", e.name, e.cyc, cyc);
                end
                if (iir !== e.iir) begin
                    n_bad++;
                    $display("FAIL %s iir: got %b expected %b", e.name, iir, e.iir);
                end
                if (irq !== exp_irq) begin
                    n_bad++;
                    $display("FAIL %s irq: got %b expected %b", e.name, irq, exp_irq);
                end
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        rst_n = 0; ier = 0; fifo_en = 0; trig = 0; rx_cnt = 0;
        rx_push = 0; rx_pop = 0; lsr_err = 0; msr_delta = 0;
        tx_empty = 0; thr_write = 0; iir_read = 0; char_tick = 0;
        nxt(); nxt();
        expect_iir(4'b0001, "reset");
        nxt(); rst_n = 1;
        expect_iir(4'b0001, "idle");

        // RX trigger level 4: interrupt one cycle after count reaches 4
        nxt(); ier = 4'b0001; fifo_en = 1; trig = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            nxt(); rx_push = 1; rx_cnt = 5'(i);
            expect_iir(i == 4 ? 4'b0100 : 4'b0001, $sformatf("rda_push%0d", i));
        end
        nxt(); expect_iir(4'b0100, "rda_hold");

        // Line status over RX data, then back
        nxt(); ier = 4'b0101; lsr_err = 1; expect_iir(4'b0110, "ls_over_rda");
        nxt(); lsr_err = 0;                expect_iir(4'b0100, "ls_drop");
        nxt(); ier = 4'b0001; lsr_err = 1; expect_iir(4'b0100, "ls_masked");
        nxt(); lsr_err = 0;

        // Trigger level boundaries
        nxt(); trig = 2'b10;               expect_iir(4'b0001, "trig8_cnt4");
        nxt(); rx_cnt = 8;                 expect_iir(4'b0100, "trig8_cnt8");
        nxt(); trig = 2'b11; rx_cnt = 13;  expect_iir(4'b0001, "trig14_cnt13");
        nxt(); rx_cnt = 14;                expect_iir(4'b0100, "trig14_cnt14");
        nxt(); ier = 4'b0000;              expect_iir(4'b0001, "erbfi_off");
        nxt(); ier = 4'b0001; fifo_en = 0; rx_cnt = 1; expect_iir(4'b0100, "nofifo_lvl1");
        nxt(); rx_pop = 1; rx_cnt = 0;     expect_iir(4'b0001, "rx_empty");

        // Character timeout: 1 char, trigger 4, four ticks
        nxt(); fifo_en = 1; trig = 2'b01; rx_push = 1; rx_cnt = 1;
        expect_iir(4'b0001, "cto_push");
        for (int t = 1; t <= 5; t++) begin
            nxt(); char_tick = 1;
            expect_iir(t >= 4 ? CtoExp : 4'b0001, $sformatf("cto_tick%0d", t));
            nxt();
            expect_iir(t >= 4 ? CtoExp : 4'b0001, $sformatf("cto_idle%0d", t));
        end
        nxt(); rx_pop = 1; rx_cnt = 0; expect_iir(4'b0001, "cto_pop");

        // Reset during the third tick restarts the count from zero
        nxt(); rx_push = 1; rx_cnt = 1;
        nxt(); char_tick = 1;
        nxt(); char_tick = 1;
        nxt(); char_tick = 1; rst_n = 0; expect_iir(4'b0001, "rst_mid_count");
        nxt(); rst_n = 1;
        for (int t = 1; t <= 4; t++) begin
            nxt(); char_tick = 1;
            expect_iir(t == 4 ? CtoExp : 4'b0001, $sformatf("cto_restart%0d", t));
        end
        nxt(); rx_pop = 1; rx_cnt = 0; expect_iir(4'b0001, "cto_restart_pop");

        // THRE via ETBEI edge, cleared by IIR read, re-armed by TX edge
        nxt(); ier = 4'b0000; tx_empty = 1; expect_iir(4'b0001, "thre_masked");
        nxt(); ier = 4'b0010;               expect_iir(4'b0010, "thre_etbei_edge");
        nxt();                              expect_iir(4'b0010, "thre_hold");
        nxt(); iir_read = 1;                expect_iir(4'b0001, "thre_iir_read");
        nxt(); tx_empty = 0;                expect_iir(4'b0001, "thre_tx_busy");
        nxt(); tx_empty = 1;                expect_iir(4'b0010, "thre_tx_edge");
        nxt(); thr_write = 1;               expect_iir(4'b0001, "thre_write_clr");

        // Set edge coincident with THR write: set wins
        nxt(); tx_empty = 0;                expect_iir(4'b0001, "thre_busy2");
        nxt(); tx_empty = 1; thr_write = 1; expect_iir(4'b0010, "thre_set_wins");
        nxt();                              expect_iir(4'b0010, "thre_set_hold");

        // THRE above modem status; modem shows once THRE clears
        nxt(); ier = 4'b1010; msr_delta = 1; expect_iir(4'b0010, "thre_over_ms");
        nxt(); thr_write = 1;                expect_iir(4'b0000, "ms_pending");
        nxt(); msr_delta = 0;                expect_iir(4'b0001, "ms_drop");

        nxt(); nxt(); nxt();
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_intr_ctrl.md
UART_INTR_CTRL -- requirements
Module: uart_intr_ctrl

Interface
- REQ-001 SHALL have parameter RxFifoDepth, default 16: RX FIFO depth; rx_fifo_cnt_i width is $clog2(RxFifoDepth+1).
- REQ-002 SHALL have parameter TimeoutChars, default 4: number of idle character times before a character-timeout interrupt.
- REQ-003 SHALL have port clk_i, input, 1: single clock; all logic is posedge clk_i.
- REQ-004 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port ier_i, input, 4: IER bits [0]=ERBFI, [1]=ETBEI, [2]=ELSI, [3]=EDSSI.
- REQ-006 SHALL have port fifo_en_i, input, 1: FCR FIFO enable.
- REQ-007 SHALL have port rx_trig_lvl_i, input, 2: RX trigger level, 00=1, 01=4, 10=8, 11=14 characters.
- REQ-008 SHALL have port rx_fifo_cnt_i, input, 5: current RX FIFO fill level.
- REQ-009 SHALL have ports rx_push_i and rx_pop_i, input, 1 each: character written to RX FIFO / RBR read by software.
- REQ-010 SHALL have port lsr_err_i, input, 1: OR of the sticky LSR OE, PE, FE and BI bits.
- REQ-011 SHALL have port msr_delta_i, input, 1: OR of the MSR d_cts, d_dsr, te_ri and d_cd bits.
- REQ-012 SHALL have ports tx_empty_i, thr_write_i and iir_read_i, input, 1 each: TX FIFO/THR empty / THR write strobe / IIR read strobe.
- REQ-013 SHALL have port char_tick_i, input, 1: one-cycle pulse once per character time from the baud generator.
- REQ-014 SHALL have port irq_o, output, 1: active-high interrupt request.
- REQ-015 SHALL have port iir_id_o, output, 4: IIR[3:0] interrupt identification.

Function
- REQ-016 SHALL encode iir_id_o by priority: line status 0110 (lsr_err_i & ELSI) > RX data available 0100 > character timeout 1100 > THRE 0010 > modem status 0000 (msr_delta_i & EDSSI) > none 0001.
- REQ-017 RX data available SHALL be asserted when ERBFI is set and rx_fifo_cnt_i >= trigger level; with fifo_en_i=0 the trigger level SHALL be 1.
- REQ-018 THRE pending SHALL set on a 0->1 edge of tx_empty_i while ETBEI=1, or on a 0->1 edge of ETBEI while tx_empty_i=1.
- REQ-019 THRE pending SHALL clear on thr_write_i, or on iir_read_i while iir_id_o==0010; if a set event and a clear event occur in the same cycle, set SHALL win.
- REQ-020 Timeout counter SHALL count char_tick_i pulses while fifo_en_i=1, ERBFI=1 and rx_fifo_cnt_i>0.
- REQ-021 Timeout counter SHALL clear on rx_push_i, on rx_pop_i, or when rx_fifo_cnt_i==0; clear SHALL win over a simultaneous tick.
- REQ-022 Timeout pending SHALL set when the counter reaches TimeoutChars; the counter SHALL saturate there and not wrap.
- REQ-023 Timeout pending SHALL clear on the same conditions as the counter.
- REQ-024 irq_o and iir_id_o SHALL be registered, updating one cycle after the causing input; irq_o SHALL equal (iir_id_o != 0001).
- REQ-025 Line status and modem status sources SHALL be level-driven; they are cleared by their owning blocks, not stored here.

Reset
- REQ-026 On rst_ni low, irq_o SHALL be 0, iir_id_o SHALL be 0001, THRE pending SHALL be 0, timeout counter and pending SHALL be 0, and edge-detect registers SHALL be 1 for tx_empty_i and 0 for ETBEI.
- REQ-027 Reset asserted mid-count SHALL discard all pending state immediately (asynchronous).

Configuration
- REQ-028 Macro UART_CHAR_TIMEOUT_EN defined: character-timeout logic per REQ-020..023 is present.
- REQ-029 Macro UART_CHAR_TIMEOUT_EN undefined: no counter is instantiated, code 1100 is never produced and char_tick_i is ignored.

Structure
- REQ-030 uart_pkg SHALL hold enum uart_iir_id_e, constants for the IER bit indices, and a function mapping trigger encoding to level.
- REQ-031 The timeout counter SHALL be sub-module uart_char_timeout, instantiated only under UART_CHAR_TIMEOUT_EN.

Verification
- REQ-032 Test: ier_i=0001, fifo_en_i=1, rx_trig_lvl_i=01, push 4 characters -> iir_id_o=0100 and irq_o=1 one cycle after count=4.
- REQ-033 Test: lsr_err_i=1 and ELSI set while RX data is pending -> iir_id_o=0110; drop lsr_err_i -> iir_id_o=0100 next cycle.
- REQ-034 Test: 1 character in FIFO with ERBFI set, trig=01, 4 char_tick_i pulses with no push/pop -> iir_id_o=1100; rx_pop_i -> 0001.
- REQ-035 Test: tx_empty_i=1, then set ETBEI -> iir_id_o=0010; iir_read_i -> 0001; later tx_empty_i 0->1 -> 0010 again.
- REQ-036 Test: THRE set edge coincident with thr_write_i -> THRE stays pending.
- REQ-037 Test: rst_ni pulsed low during 3rd tick -> irq_o=0, iir_id_o=0001, timeout restarts from 0.
